// File: rtl/pipe_muxn.sv
// pipe_muxn: N-way select mux feeding a registered output stage backed by a
// one-entry skid register, under a valid/ready handshake. Out-of-range selects
// produce zero data with an error tag and bump a saturating error counter.
module pipe_muxn #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              err_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic             out_err_reg, out_err_next;
  logic [WIDTH-1:0] skid_data_reg, skid_data_next;
  logic             skid_err_reg, skid_err_next;
  logic [7:0]       err_cnt_reg, err_cnt_next;

  logic [WIDTH-1:0] slice [NUM_IN];
  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic             acc;
  logic             push;

  // Unpack the flat input bus into one slice per input
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_slice
      assign slice[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Select the addressed slice; an unmatched select yields zero data and the error tag
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_data = slice[k];
        sel_err  = 1'b0;
      end
    end
  end

  // Ready depends only on occupancy so there is no combinational path from out_ready
  assign in_ready = rst_n & (state_reg != FULL);
  assign acc      = in_valid & in_ready;
  assign push     = out_valid & out_ready;

  // Next-state, datapath loads and error counting; flush overrides everything
  always_comb begin
    state_next     = state_reg;
    out_data_next  = out_data_reg;
    out_err_next   = out_err_reg;
    skid_data_next = skid_data_reg;
    skid_err_next  = skid_err_reg;
    err_cnt_next   = err_cnt_reg;
    if (flush) begin
      // out_data deliberately keeps its old value; only the tag and occupancy clear
      state_next   = EMPTY;
      out_err_next = 1'b0;
    end else begin
      if (acc && sel_err && (err_cnt_reg != 8'hFF)) begin
        err_cnt_next = err_cnt_reg + 8'd1;
      end
      case (state_reg)
        EMPTY: begin
          if (acc) begin
            out_data_next = sel_data;
            out_err_next  = sel_err;
            state_next    = ONE;
          end
        end
        ONE: begin
          if (acc && push) begin
            out_data_next = sel_data;
            out_err_next  = sel_err;
          end else if (acc) begin
            skid_data_next = sel_data;
            skid_err_next  = sel_err;
            state_next     = FULL;
          end else if (push) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (push) begin
            out_data_next = skid_data_reg;
            out_err_next  = skid_err_reg;
            state_next    = ONE;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= EMPTY;
      out_data_reg  <= '0;
      out_err_reg   <= 1'b0;
      skid_data_reg <= '0;
      skid_err_reg  <= 1'b0;
      err_cnt_reg   <= 8'd0;
    end else begin
      state_reg     <= state_next;
      out_data_reg  <= out_data_next;
      out_err_reg   <= out_err_next;
      skid_data_reg <= skid_data_next;
      skid_err_reg  <= skid_err_next;
      err_cnt_reg   <= err_cnt_next;
    end
  end

  assign out_valid   = (state_reg != EMPTY);
  assign out_data    = out_data_reg;
  assign out_sel_err = out_err_reg;
  assign err_cnt     = err_cnt_reg;

endmodule
